reg_file_mp: RTL

- Parametrised successor to the single-write, three-read register file of the multicycle MIPS core.
- NUM_RD registered read ports, each with a per-port immediate-passthrough select that generalises the shamt path.
- Two prioritised write ports, so a writeback and a second producer such as a link-register write can land in the same cycle.
- A sequenced bulk-clear engine with a BUSY handshake, so the register contents can be wiped without asserting global reset.

---
 rtl/reg_file_pkg.sv | 15 +
 rtl/reg_file_rd_port.sv | 60 ++++++
 rtl/reg_file_mp.sv | 112 +++++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and types for the multi-port register file.
package reg_file_pkg;

  localparam int unsigned DefaultAddrW = 5;
  localparam int unsigned DefaultDataW = 32;

  // Entry 0 reads as zero and never stores a write
  localparam int unsigned ZeroAddr = 0;

  typedef enum logic {
    StIdle,
    StClear
  } rf_state_e;

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port: decode, optional same-cycle write bypass, immediate mux.
// Bypass is compiled in when REG_FILE_BYPASS_EN is defined.
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int unsigned ADDR_W = DefaultAddrW,
  parameter int unsigned DATA_W = DefaultDataW
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] ra_i,
  input  logic              rimm_sel_i,
  input  logic [DATA_W-1:0] mem_i [2**ADDR_W],
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] wa0_i,
  input  logic [DATA_W-1:0] wd0_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] wa1_i,
  input  logic [DATA_W-1:0] wd1_i,
  output logic [DATA_W-1:0] rd_o
);

  logic [DATA_W-1:0] value;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] rd_d;
  logic [DATA_W-1:0] rd_q;

  // we*_i are already qualified as committing writes (nonzero address, FSM idle)
  always_comb begin
    value = (ra_i == ADDR_W'(ZeroAddr)) ? '0 : mem_i[ra_i];
`ifdef REG_FILE_BYPASS_EN
    if (ra_i != ADDR_W'(ZeroAddr)) begin
      if (we1_i && (wa1_i == ra_i)) begin
        value = wd1_i;
      end else if (we0_i && (wa0_i == ra_i)) begin
        value = wd0_i;
      end
    end
`endif
    imm                = '0;
    imm[ADDR_W-1:0]    = ra_i;
    rd_d               = rimm_sel_i ? imm : value;
  end

`ifndef REG_FILE_BYPASS_EN
  logic unused_byp;
  assign unused_byp = ^{we0_i, wa0_i, wd0_i, we1_i, wa1_i, wd1_i};
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign rd_o = rd_q;

endmodule

// File: rtl/reg_file_mp.sv
// Register file with NUM_RD registered read ports, two prioritised write ports and a
// sequenced bulk-clear engine. Optional same-cycle write bypass: REG_FILE_BYPASS_EN.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int unsigned ADDR_W = DefaultAddrW,
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned NUM_RD = 3
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_RD*ADDR_W-1:0] RA,
  input  logic [NUM_RD-1:0]        RIMM_SEL,
  input  logic                     WE0,
  input  logic [ADDR_W-1:0]        WA0,
  input  logic [DATA_W-1:0]        WD0,
  input  logic                     WE1,
  input  logic [ADDR_W-1:0]        WA1,
  input  logic [DATA_W-1:0]        WD1,
  input  logic                     CLR_REQ,
  output logic                     BUSY,
  output logic [NUM_RD*DATA_W-1:0] RD
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              we0_c;
  logic              we1_c;

  assign we0_c = WE0 && (WA0 != ADDR_W'(ZeroAddr)) && (state_q == StIdle);
  assign we1_c = WE1 && (WA1 != ADDR_W'(ZeroAddr)) && (state_q == StIdle);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (CLR_REQ) begin
          state_d = StClear;
          idx_d   = ADDR_W'(1);
        end
      end
      StClear: begin
        // Terminate on the last index rather than relying on wrap-around
        if (idx_q == ADDR_W'(DEPTH - 1)) begin
          state_d = StIdle;
          idx_d   = ADDR_W'(1);
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = ADDR_W'(1);
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      idx_q   <= ADDR_W'(1);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Port 1 is written last so it wins an address collision
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (state_q == StClear) begin
      mem_q[idx_q] <= '0;
    end else begin
      if (we0_c) begin
        mem_q[WA0] <= WD0;
      end
      if (we1_c) begin
        mem_q[WA1] <= WD1;
      end
    end
  end

  assign BUSY = (state_q == StClear);

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    reg_file_rd_port #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
    ) u_rd_port (
      .CLK       (CLK),
      .RST       (RST),
      .ra_i      (RA[p*ADDR_W +: ADDR_W]),
      .rimm_sel_i(RIMM_SEL[p]),
      .mem_i     (mem_q),
      .we0_i     (we0_c),
      .wa0_i     (WA0),
      .wd0_i     (WD0),
      .we1_i     (we1_c),
      .wa1_i     (WA1),
      .wd1_i     (WD1),
      .rd_o      (RD[p*DATA_W +: DATA_W])
    );
  end

endmodule
